// File: rtl/scanout_arbiter.sv
// scanout_arbiter: shares one single-port pixel RAM between HDMI scanout and a
// host valid/ready port. During active video every fourth cycle is a scanout
// fetch of one 4-pixel word. The remaining cycles are host slots. Fetched words
// are serialised to one pixel per clock.
// Optional feature macro: SCANOUT_ARB_READBACK_EN (host reads via wr_we/rd_data/rd_valid).
module scanout_arbiter #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned PIX_W    = 8,
  parameter int unsigned FB_WORDS = 76800
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 fetch_active,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [4*PIX_W-1:0]   wr_data,
`ifdef SCANOUT_ARB_READBACK_EN
  input  logic                 wr_we,
  output logic [4*PIX_W-1:0]   rd_data,
  output logic                 rd_valid,
`endif
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [4*PIX_W-1:0]   ram_wdata,
  input  logic [4*PIX_W-1:0]   ram_rdata,
  output logic [PIX_W-1:0]     pix_out,
  output logic                 pix_valid
);

  localparam int unsigned      WORD_W    = 4 * PIX_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

  logic [1:0]          r_phase;
  logic [ADDR_W-1:0]   r_vid_addr;
  logic                r_ram_en;
  logic                r_ram_we;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic [WORD_W-1:0]   r_ram_wdata;
  logic                r_vid_p1;
  logic                r_vid_p2;
  logic                r_fa1;
  logic                r_fa2;
  logic                r_pix_valid;
  logic [PIX_W-1:0]    r_pix_out;
  logic [3*PIX_W-1:0]  r_shift;

  logic                w_video_slot;
  logic                w_wr_ready;
  logic                w_host_acc;
  logic                w_is_wr;
  logic [ADDR_W-1:0]   w_fetch_addr;
  logic [ADDR_W-1:0]   w_vid_addr_nxt;

  // Slot decode: a fetch on phase 0 of every active run, host otherwise
  assign w_video_slot   = fetch_active && (r_phase == 2'd0);
  assign w_wr_ready     = !reset && !w_video_slot;
  assign w_host_acc     = wr_valid && w_wr_ready;
  assign w_fetch_addr   = frame_start ? '0 : r_vid_addr;
  assign w_vid_addr_nxt = (w_fetch_addr == LAST_ADDR) ? '0 : w_fetch_addr + ADDR_W'(1);

`ifdef SCANOUT_ARB_READBACK_EN
  assign w_is_wr = wr_we;
`else
  assign w_is_wr = 1'b1;
`endif

  // Phase counter restarts at 0 on every active run
  always_ff @(posedge clk_pixel) begin
    if (reset || !fetch_active) r_phase <= 2'd0;
    else                        r_phase <= r_phase + 2'd1;
  end

  // Video word address: advances per fetch, wraps at end of frame
  always_ff @(posedge clk_pixel) begin
    if (reset)             r_vid_addr <= '0;
    else if (w_video_slot) r_vid_addr <= w_vid_addr_nxt;
    else if (frame_start)  r_vid_addr <= '0;
  end

  // RAM port: one access per cycle, video fetch has priority on its slot
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else if (w_video_slot) begin
      r_ram_en   <= 1'b1;
      r_ram_we   <= 1'b0;
      r_ram_addr <= w_fetch_addr;
    end else if (w_host_acc) begin
      r_ram_en   <= 1'b1;
      r_ram_we   <= w_is_wr;
      r_ram_addr <= wr_addr;
      if (w_is_wr) r_ram_wdata <= wr_data;
    end else begin
      r_ram_en <= 1'b0;
      r_ram_we <= 1'b0;
    end
  end

  // Scanout pipeline: slot -> address -> data -> serialised pixels
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_vid_p1    <= 1'b0;
      r_vid_p2    <= 1'b0;
      r_fa1       <= 1'b0;
      r_fa2       <= 1'b0;
      r_pix_valid <= 1'b0;
      r_pix_out   <= '0;
      r_shift     <= '0;
    end else begin
      r_vid_p1    <= w_video_slot;
      r_vid_p2    <= r_vid_p1;
      r_fa1       <= fetch_active;
      r_fa2       <= r_fa1;
      r_pix_valid <= r_fa2;
      if (r_vid_p2) begin
        r_pix_out <= r_fa2 ? ram_rdata[PIX_W-1:0] : '0;
        r_shift   <= ram_rdata[WORD_W-1:PIX_W];
      end else begin
        r_pix_out <= r_fa2 ? r_shift[PIX_W-1:0] : '0;
        r_shift   <= {{PIX_W{1'b0}}, r_shift[3*PIX_W-1:PIX_W]};
      end
    end
  end

`ifdef SCANOUT_ARB_READBACK_EN
  logic r_rd_p1;
  logic r_rd_p2;

  // Host read return: data arrives two cycles after acceptance
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
    end else begin
      r_rd_p1 <= w_host_acc && !w_is_wr;
      r_rd_p2 <= r_rd_p1;
    end
  end

  assign rd_valid = r_rd_p2;
  assign rd_data  = r_rd_p2 ? ram_rdata : '0;
`endif

  assign wr_ready  = w_wr_ready;
  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign pix_out   = r_pix_out;
  assign pix_valid = r_pix_valid;

endmodule

// File: doc/scanout_arbiter.md
# scanout_arbiter

Shares one single-port pixel RAM between the HDMI scanout path and a host writer, in the `clk_pixel` domain between the VGA timing generator and the `vga2dvid` encoder. During active video it reserves every fourth RAM cycle for a scanout fetch of one 4-pixel word. All other cycles go to a valid/ready write port. It serialises fetched words into one pixel per clock with fixed latency relative to the timing generator's early-active strobe.

## Interface
Parameters:
- `ADDR_W`, 17: RAM word address width.
- `PIX_W`, 8: bits per pixel. RAM word width is `4*PIX_W`.
- `FB_WORDS`, 76800: words per frame (640x480/4). The video address wraps here.

Ports:
- `clk_pixel`  in  1: the single clock (25 MHz pixel clock).
- `reset`  in  1: synchronous, active-high reset.
- `frame_start`  in  1: one-cycle pulse at the first cycle of each frame.
- `fetch_active`  in  1: display-active strobe, advanced 3 cycles relative to the pixel it refers to.
- `wr_valid`  in  1: host write request.
- `wr_ready`  out  1: write accepted this cycle if `wr_valid` is high.
- `wr_addr`  in  `ADDR_W`: host word address.
- `wr_data`  in  `4*PIX_W`: host word. Pixel 0 is in the LSBs.
- `ram_en`  out  1: RAM access strobe (registered).
- `ram_we`  out  1: RAM write enable (registered).
- `ram_addr`  out  `ADDR_W`: RAM address (registered).
- `ram_wdata`  out  `4*PIX_W`: RAM write data (registered).
- `ram_rdata`  in  `4*PIX_W`: RAM read data, valid 1 cycle after `ram_en` with `ram_we`=0.
- `pix_out`  out  `PIX_W`: serialised pixel. Zero when not valid.
- `pix_valid`  out  1: `fetch_active` delayed 3 cycles.

## Operation
- `phase` is a 2-bit counter.
  - Cleared whenever `fetch_active`=0.
  - Otherwise increments mod 4 each cycle.
  - Every active run therefore starts at phase 0.
- A video slot is a cycle with `fetch_active`=1 and `phase`=0. All other cycles are host slots.
- `wr_ready` is combinational: `!reset && !video_slot`.
- Video slot: next cycle drives `ram_en`=1, `ram_we`=0, `ram_addr`=`vid_addr`. Then `vid_addr` increments, wrapping from `FB_WORDS-1` to 0.
- Host slot with `wr_valid`=1: next cycle drives `ram_en`=1, `ram_we`=1, `ram_addr`=`wr_addr`, `ram_wdata`=`wr_data`.
- Host slot with `wr_valid`=0: next cycle drives `ram_en`=0 and `ram_we`=0. `ram_addr` and `ram_wdata` hold their values.
- `frame_start` sets `vid_addr` to 0.
  - If coincident with a video slot, that fetch uses address 0 and `vid_addr` becomes 1.
- Fetched data is captured into a 4-pixel shift register 2 cycles after its video slot. The register shifts one pixel per cycle, LSB pixel first.
- When `pix_valid`=0, `pix_out` is 0.
- An active run whose length is not a multiple of 4 discards the unused pixels of the last word. The next run refetches from the next word.
- Reset values:
  - `phase`=0, `vid_addr`=0.
  - `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
  - `pix_out`=0, `pix_valid`=0.
  - Shift register cleared, readback pipeline cleared.
- Reset asserted mid-line aborts the fetch in progress. No RAM strobe is driven in the cycle after reset.

## Timing
- Video slot at cycle t:
  - `ram_addr` valid at t+1.
  - `ram_rdata` valid at t+2.
  - Pixels 0..3 on `pix_out` at t+3..t+6.
  - The next slot is t+4, so its pixels appear at t+7..t+10 with no gap.
- Host write accepted at t appears on the RAM port at t+1.
- Host throughput:
  - During active video, 3 of every 4 cycles.
  - During blanking, every cycle.
- Worst-case `wr_ready` low time is 1 cycle.

## Configuration
- `SCANOUT_ARB_READBACK_EN`
  - Defined: adds host reads.
    - Input `wr_we` (1 = write, 0 = read). It shares `wr_valid`, `wr_ready` and `wr_addr`.
    - Output `rd_data` (`4*PIX_W`).
    - Output `rd_valid`: a one-cycle pulse 2 cycles after acceptance, carrying `ram_rdata`.
    - Read slots drive `ram_we`=0 and do not disturb the scanout shift register.
  - Undefined: no `wr_we`, `rd_data` or `rd_valid` ports. Every accepted request is a write.

## Test plan
- Reset, then `fetch_active` high for 8 cycles, with RAM words 0/1 = 0x03020100 / 0x07060504 -> `pix_out` 00..07 on cycles t+3..t+10, `pix_valid` high for exactly those cycles.
- `wr_valid` held high through an 8-cycle active run -> `wr_ready` low only at active cycles 0 and 4. Exactly 6 writes reach the RAM port, each 1 cycle after acceptance.
- Blanking with 10 back-to-back writes -> 10 consecutive `ram_we`=1 cycles with matching addresses and data.
- Run `vid_addr` to 76799 and fetch twice -> `ram_addr` 76799 then 0. A `frame_start` coincident with a video slot -> that fetch uses `ram_addr`=0 and the next uses 1.
- Assert `reset` at cycle t+1 of a line -> the next cycle shows `ram_en`=0, `pix_out`=0, `pix_valid`=0 and `wr_ready`=0. After release, the first fetch uses address 0.
- With `SCANOUT_ARB_READBACK_EN` defined: write 0xDEADBEEF to address 5, then read address 5 -> `rd_valid` pulses 2 cycles after read acceptance with `rd_data`=0xDEADBEEF.
